// File: rtl/sccb_pkg.sv
// Shared SCCB definitions: camera device ID, target FSM states
// and bit-counter width.
package sccb_pkg;

  localparam logic [6:0] CAM_ADDR = 7'h21;
  localparam int unsigned CNT_W = 4;

  typedef enum logic [3:0] {
    S_IDLE,
    S_DEV,
    S_DEV_ACK,
    S_SUB,
    S_SUB_ACK,
    S_WDATA,
    S_WDATA_ACK,
    S_RDATA,
    S_RD_NA,
    S_IGNORE
  } sccb_tgt_state_t;

endpackage

// File: rtl/sccb_line_sync.sv
// SCL/SDA synchronizers plus a registered edge/condition detector
// producing SCL edges, START, STOP and the aligned SDA level.
module sccb_line_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_scl,
  input  logic i_sda,
  output logic o_scl_rise,
  output logic o_scl_fall,
  output logic o_start_det,
  output logic o_stop_det,
  output logic o_sda_s
);

  logic [SYNC_STAGES-1:0] scl_sync_q;
  logic [SYNC_STAGES-1:0] sda_sync_q;
  logic                   scl_q;
  logic                   sda_q;
  logic                   rise_q;
  logic                   fall_q;
  logic                   start_q;
  logic                   stop_q;
  logic                   sda_out_q;
  logic                   scl_s;
  logic                   sda_s;

  assign scl_s = scl_sync_q[SYNC_STAGES-1];
  assign sda_s = sda_sync_q[SYNC_STAGES-1];

  // Events are registered so they line up with sda_out_q.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_q      <= 1'b1;
      sda_q      <= 1'b1;
      rise_q     <= 1'b0;
      fall_q     <= 1'b0;
      start_q    <= 1'b0;
      stop_q     <= 1'b0;
      sda_out_q  <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], i_scl};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], i_sda};
      scl_q      <= scl_s;
      sda_q      <= sda_s;
      rise_q     <= scl_s & ~scl_q;
      fall_q     <= ~scl_s & scl_q;
      start_q    <= scl_s & scl_q & sda_q & ~sda_s;
      stop_q     <= scl_s & scl_q & ~sda_q & sda_s;
      sda_out_q  <= sda_s;
    end
  end

  assign o_scl_rise  = rise_q;
  assign o_scl_fall  = fall_q;
  assign o_start_det = start_q;
  assign o_stop_det  = stop_q;
  assign o_sda_s     = sda_out_q;

endmodule

// File: rtl/sccb_target.sv
// SCCB responder with a 256x8 register file, write strobe and
// a registered debug read port.
module sccb_target
  import sccb_pkg::*;
#(
  parameter logic [6:0]  DEV_ID      = CAM_ADDR,
  parameter int unsigned SYNC_STAGES = 2,
  parameter bit          ACK_EN      = 1'b1
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_scl,
  input  logic       i_sda,
  output logic       o_sda_low,
  output logic       o_wr_valid,
  output logic [7:0] o_wr_addr,
  output logic [7:0] o_wr_data,
  output logic       o_busy,
  input  logic [7:0] i_dbg_addr,
  output logic [7:0] o_dbg_data
);

  logic scl_rise;
  logic scl_fall;
  logic start_det;
  logic stop_det;
  logic sda_s;

  sccb_line_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_scl      (i_scl),
    .i_sda      (i_sda),
    .o_scl_rise (scl_rise),
    .o_scl_fall (scl_fall),
    .o_start_det(start_det),
    .o_stop_det (stop_det),
    .o_sda_s    (sda_s)
  );

  sccb_tgt_state_t  state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [7:0]       shift_q;
  logic [7:0]       tx_q;
  logic [7:0]       ptr_q;
  logic             rd_q;
  logic             sda_low_q;
  logic             wr_valid_q;
  logic [7:0]       wr_addr_q;
  logic [7:0]       wr_data_q;
  logic             busy_q;
  logic [7:0]       dbg_q;
  logic [7:0]       regs_q [256];

  logic [7:0]       rx_d;
  logic             last_bit;
  logic [7:0]       rd_byte;

  assign rx_d     = {shift_q[6:0], sda_s};
  assign last_bit = (cnt_q == CNT_W'(7));
  assign rd_byte  = regs_q[ptr_q];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      shift_q    <= '0;
      tx_q       <= '0;
      ptr_q      <= '0;
      rd_q       <= 1'b0;
      sda_low_q  <= 1'b0;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      busy_q     <= 1'b0;
      dbg_q      <= '0;
      for (int i = 0; i < 256; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      wr_valid_q <= 1'b0;
      dbg_q      <= regs_q[i_dbg_addr];
      if (stop_det) begin
        state_q   <= S_IDLE;
        cnt_q     <= '0;
        sda_low_q <= 1'b0;
        busy_q    <= 1'b0;
      end else if (start_det) begin
        state_q   <= S_DEV;
        cnt_q     <= '0;
        sda_low_q <= 1'b0;
        busy_q    <= 1'b0;
      end else begin
        case (state_q)
          S_DEV: begin
            if (scl_rise) begin
              shift_q <= rx_d;
              cnt_q   <= cnt_q + CNT_W'(1);
              if (last_bit) begin
                cnt_q <= '0;
                if (rx_d[7:1] == DEV_ID) begin
                  state_q <= S_DEV_ACK;
                  rd_q    <= rx_d[0];
                  busy_q  <= 1'b1;
                end else begin
                  state_q <= S_IGNORE;
                end
              end
            end
          end
          S_SUB, S_WDATA: begin
            if (scl_rise) begin
              shift_q <= rx_d;
              cnt_q   <= cnt_q + CNT_W'(1);
              if (last_bit) begin
                cnt_q <= '0;
                if (state_q == S_SUB) begin
                  ptr_q   <= rx_d;
                  state_q <= S_SUB_ACK;
                end else begin
                  regs_q[ptr_q] <= rx_d;
                  wr_valid_q    <= 1'b1;
                  wr_addr_q     <= ptr_q;
                  wr_data_q     <= rx_d;
                  ptr_q         <= ptr_q + 8'd1;
                  state_q       <= S_WDATA_ACK;
                end
              end
            end
          end
          S_DEV_ACK, S_SUB_ACK, S_WDATA_ACK: begin
            // First fall drives the ACK, second fall ends the 9th bit.
            if (scl_fall) begin
              if (cnt_q == '0) begin
                sda_low_q <= ACK_EN;
                cnt_q     <= CNT_W'(1);
              end else if (state_q == S_DEV_ACK && rd_q) begin
                state_q   <= S_RDATA;
                tx_q      <= {rd_byte[6:0], 1'b0};
                sda_low_q <= ~rd_byte[7];
                cnt_q     <= CNT_W'(1);
              end else begin
                sda_low_q <= 1'b0;
                cnt_q     <= '0;
                state_q   <= (state_q == S_DEV_ACK) ? S_SUB : S_WDATA;
              end
            end
          end
          S_RDATA: begin
            if (scl_fall) begin
              if (cnt_q == '0) begin
                tx_q      <= {rd_byte[6:0], 1'b0};
                sda_low_q <= ~rd_byte[7];
                cnt_q     <= CNT_W'(1);
              end else if (cnt_q < CNT_W'(8)) begin
                tx_q      <= {tx_q[6:0], 1'b0};
                sda_low_q <= ~tx_q[7];
                cnt_q     <= cnt_q + CNT_W'(1);
              end else begin
                sda_low_q <= 1'b0;
                cnt_q     <= '0;
                state_q   <= S_RD_NA;
              end
            end
          end
          S_RD_NA: begin
            if (scl_rise) begin
              ptr_q   <= ptr_q + 8'd1;
              cnt_q   <= '0;
              state_q <= S_RDATA;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign o_sda_low  = sda_low_q;
  assign o_wr_valid = wr_valid_q;
  assign o_wr_addr  = wr_addr_q;
  assign o_wr_data  = wr_data_q;
  assign o_busy     = busy_q;
  assign o_dbg_data = dbg_q;

endmodule

// File: doc/sccb_target.md
# sccb_target

SCCB target (responder) for the OV7670 camera interface. It sits on the same two-wire bus as the SCCB master controller and answers at device ID 7'h21 with a 256 x 8 register file. It decodes 3-phase write cycles and 2-phase write plus 2-phase read sequences, and reports every completed register write on a one-cycle strobe. It serves as the camera bus model in system simulation and as a loopback target in FPGA bring-up.

## Interface
- `DEV_ID`, 7'h21: 7-bit device ID this target answers to.
- `SYNC_STAGES`, 2: flip-flop depth of the SCL/SDA input synchronizers (minimum 2).
- `ACK_EN`, 1: 1 = drive 0 on the 9th bit after an accepted write-direction byte; 0 = leave the 9th bit released.
- `i_clk`, in, 1: system clock. Must be at least 8x the SCL frequency.
- `i_rst`, in, 1: synchronous, active-high reset.
- `i_scl`, in, 1: SCL pin level (pulled-up bus).
- `i_sda`, in, 1: SDA pin level.
- `o_sda_low`, out, 1: 1 = pull SDA low (open-drain enable). The top level drives `io_sda = o_sda_low ? 0 : Z`.
- `o_wr_valid`, out, 1: one-cycle tick when a data byte has been written into the register file.
- `o_wr_addr`, out, 8: register address of that write. Valid while `o_wr_valid` is high.
- `o_wr_data`, out, 8: data of that write. Valid while `o_wr_valid` is high.
- `o_busy`, out, 1: high from an accepted device-ID byte until the next STOP, START or reset.
- `i_dbg_addr`, in, 8: side-port read address.
- `o_dbg_data`, out, 8: register-file content at `i_dbg_addr`, registered with 1-cycle latency.

## Operation
- **Line conditioning.** SCL and SDA pass through `SYNC_STAGES` synchronizers, then a 1-flop edge detector.
  - SCL rise: sample point. SCL fall: drive point.
  - START: SDA falls while SCL is high. STOP: SDA rises while SCL is high.
- **START or repeated START:** from any state, clear the bit counter, release SDA, go to DEV.
- **STOP:** from any state, release SDA, go to IDLE, clear `o_busy`. The register file and the sub-address pointer are kept.
- **States:** IDLE, DEV, DEV_ACK, SUB, SUB_ACK, WDATA, WDATA_ACK, RDATA, RD_NA, IGNORE.
- **DEV.** Shift in 8 bits MSB first on SCL rises.
  - If bits[7:1] == `DEV_ID` and bit0 = 0 (write): go to DEV_ACK, set `o_busy`.
  - If bits[7:1] == `DEV_ID` and bit0 = 1 (read): go to DEV_ACK, then RDATA.
  - Mismatch: go to IGNORE and stay there until START or STOP; SDA is never driven.
- **xx_ACK states.** On the SCL fall after the 8th bit, assert `o_sda_low` = `ACK_EN`. Release SDA on the next SCL fall.
- **SUB.** The received byte loads the pointer `ptr`. Next state: WDATA.
- **WDATA.**
  - The received byte is written to `regs[ptr]`.
  - `o_wr_valid` pulses at the 8th-bit sample cycle + 1, with `o_wr_addr = ptr` and `o_wr_data = byte`.
  - `ptr` then increments, wrapping 8'hFF -> 8'h00.
  - Further bytes continue writing at consecutive addresses.
- **RDATA.**
  - Bit 7 of `regs[ptr]` is driven on the SCL fall ending DEV_ACK. Each later bit is driven on each SCL fall, MSB first.
  - `o_sda_low = ~bit`, so 1 bits release the line.
  - After bit 0, go to RD_NA and release SDA.
  - Sample the 9th bit. Either level returns to RDATA with `ptr + 1` (SCCB NA is don't-care). The master ends the read with STOP.
- **Register file.** Sub-address and data bytes are always 8 bits, so there is no width overflow. A write and a debug read of the same address in the same cycle returns the old value.

## Timing
- Pin-to-event latency: `SYNC_STAGES` + 1 clocks.
- `o_sda_low` changes exactly 1 clock after the detected SCL-fall event. This gives 0 ns hold at the pin plus the synchronizer delay, which meets SCCB hold with SCL high/low phases of at least 4 clocks.
- `o_wr_valid`: exactly one cycle per data byte. Never asserted for a device-ID or sub-address byte.
- **Reset values:** `o_sda_low` = 0, `o_wr_valid` = 0, `o_wr_addr` = 0, `o_wr_data` = 0, `o_busy` = 0, `o_dbg_data` = 0, `ptr` = 0, all `regs` = 8'h00, state = IDLE, synchronizer flops = 1.
- **Reset mid-byte:** SDA is released the next cycle. A partial byte is discarded and never written.
- **START or STOP mid-byte:** the partial byte is discarded with no `o_wr_valid`.
- **STOP while `o_sda_low` = 1:** SDA releases the cycle after detection.

## Structure
- Package `sccb_pkg`:
  - `CAM_ADDR` = 7'h21, also used by the master instance.
  - State enum `sccb_tgt_state_t`.
  - Bit-count width constant (4 bits, counts 0..8).
- Sub-module `sccb_line_sync`, one instance for both lines. It holds the synchronizers and edge detector and outputs `scl_rise`, `scl_fall`, `start_det`, `stop_det`, `sda_s`.
- The top holds the FSM, the shift register, `ptr` and the register file. Expected size: about 250 lines.

## Test plan
1. **3-phase write.** START, 8'h42, 8'h12, 8'h80, STOP -> one `o_wr_valid` with addr 8'h12 and data 8'h80; `i_dbg_addr` = 8'h12 returns 8'h80; SDA low on each 9th bit.
2. **Read back.** START, 8'h42, 8'h12, STOP, START, 8'h43, master clocks 9 bits, STOP -> master receives 8'h80; no `o_wr_valid`.
3. **Wrong ID.** START, 8'h60, 8'h12, 8'h55, STOP -> SDA never driven; `regs[8'h12]` unchanged; `o_busy` stays 0.
4. **Burst and wrap.** START, 8'h42, 8'hFF, 8'hA1, 8'hA2, STOP -> writes (FF, A1) then (00, A2).
5. **Abort.** STOP after 4 bits of a data byte, and separately `i_rst` asserted mid-read -> no write; SDA released within `SYNC_STAGES` + 2 clocks; all outputs at reset values.
6. **Master loopback.** Master controller instance at 100 MHz / 400 kHz writes register 8'h3A = 8'h04 -> target logs the same write; master `o_ack` = 0.
